// File: rtl/ascon_text_unpacker_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ascon_text_unpacker_pkg
//  Brief    : Shared types and helpers for the ASCON output-block unpacker.
//  Revision : 1.0  initial release
// ============================================================================
package ascon_text_unpacker_pkg;

    localparam int LEN_W = 7;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_BLK = 3'd1,
        SEND_HI  = 3'd2,
        SEND_LO  = 3'd3,
        DONE     = 3'd4
    } unpack_state_t;

    // Number of 32-bit words needed to carry size bytes, i.e. ceil(size/4).
    function automatic logic [LEN_W-1:0] len_in_words(input logic [LEN_W-1:0] size);
        logic [LEN_W:0] sum;
        sum = {1'b0, size} + (LEN_W+1)'(3);
        return LEN_W'(sum >> 2);
    endfunction

    function automatic logic [3:0] tail_mask(input logic [1:0] rem);
        logic [3:0] mask;
        case (rem)
            2'd1:    mask = 4'h8;
            2'd2:    mask = 4'hC;
            2'd3:    mask = 4'hE;
            default: mask = 4'hF;
        endcase
        return mask;
    endfunction

    // Mask bit 3 governs bits [31:24], the first byte on the wire.
    function automatic logic [31:0] trim_word(input logic [31:0] data, input logic [3:0] mask);
        logic [31:0] out;
        out = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) out[8*i +: 8] = data[8*i +: 8];
        end
        return out;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ascon_text_unpacker_if.sv
`default_nettype none
// ============================================================================
//  Module   : ascon_text_unpacker_if
//  Brief    : Control, core-side block and host-side word signals of the unpacker.
//  Revision : 1.0  initial release
// ============================================================================
interface ascon_text_unpacker_if #(
    parameter int SIZE_W = 7
);
    logic              start_i;
    logic [SIZE_W-1:0] text_size_i;
    logic              blk_valid_i;
    logic [63:0]       blk_data_i;
    logic              blk_ready_o;
    logic              word_valid_o;
    logic [31:0]       word_data_o;
    logic [3:0]        word_vld_byte_o;
    logic              word_last_o;
    logic              word_ready_i;
    logic              busy_o;
    logic              done_o;

    modport master (
        output start_i, text_size_i, blk_valid_i, blk_data_i, word_ready_i,
        input  blk_ready_o, word_valid_o, word_data_o, word_vld_byte_o,
               word_last_o, busy_o, done_o
    );

    modport slave (
        input  start_i, text_size_i, blk_valid_i, blk_data_i, word_ready_i,
        output blk_ready_o, word_valid_o, word_data_o, word_vld_byte_o,
               word_last_o, busy_o, done_o
    );
endinterface
`default_nettype wire

// File: rtl/ascon_text_unpacker.sv
`default_nettype none
// ============================================================================
//  Module   : ascon_text_unpacker
//  Brief    : Splits 64-bit ASCON output blocks into a trimmed 32-bit word stream.
//  Revision : 1.0  initial release
// ============================================================================
module ascon_text_unpacker
    import ascon_text_unpacker_pkg::*;
#(
    parameter int SIZE_W = 7
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    ascon_text_unpacker_if.slave  bus
);

    unpack_state_t    state, next_state;
    logic [63:0]      blk_buf;
    logic [LEN_W-1:0] words_left;
    logic [1:0]       tail_rem;
    logic             empty_hold;

    logic [LEN_W-1:0] words_total;
    logic             size_zero;
    logic             blk_ready;
    logic             word_valid;
    logic             word_last;
    logic             done;
    logic [31:0]      half;
    logic [3:0]       mask;

    assign words_total = len_in_words(LEN_W'(bus.text_size_i));
    assign size_zero   = (bus.text_size_i == '0);

    always_comb begin
        next_state = state;
        blk_ready  = 1'b0;
        word_valid = 1'b0;
        done       = 1'b0;
        half       = 32'h0;
        case (state)
            IDLE: begin
                if (bus.start_i) next_state = size_zero ? DONE : WAIT_BLK;
            end
            WAIT_BLK: begin
                blk_ready = 1'b1;
                if (bus.blk_valid_i) next_state = SEND_HI;
            end
            SEND_HI: begin
                word_valid = 1'b1;
                half       = blk_buf[63:32];
                if (bus.word_ready_i) next_state = (words_left == LEN_W'(1)) ? DONE : SEND_LO;
            end
            SEND_LO: begin
                word_valid = 1'b1;
                half       = blk_buf[31:0];
                if (bus.word_ready_i) next_state = (words_left == LEN_W'(1)) ? DONE : WAIT_BLK;
            end
            DONE: begin
                // An empty message idles here one extra cycle before signalling completion.
                if (!empty_hold) begin
                    done       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign word_last = word_valid && (words_left == LEN_W'(1));
    assign mask      = !word_valid ? 4'h0 : (word_last ? tail_mask(tail_rem) : 4'hF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            blk_buf    <= 64'h0;
            words_left <= '0;
            tail_rem   <= 2'd0;
            empty_hold <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        tail_rem   <= bus.text_size_i[1:0];
                        words_left <= words_total;
                        empty_hold <= size_zero;
                    end
                end
                WAIT_BLK: begin
                    if (bus.blk_valid_i) blk_buf <= bus.blk_data_i;
                end
                SEND_HI, SEND_LO: begin
                    if (bus.word_ready_i) words_left <= words_left - LEN_W'(1);
                end
                DONE: empty_hold <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.blk_ready_o     = blk_ready;
    assign bus.word_valid_o    = word_valid;
    assign bus.word_data_o     = trim_word(half, mask);
    assign bus.word_vld_byte_o = mask;
    assign bus.word_last_o     = word_last;
    assign bus.busy_o          = (state != IDLE);
    assign bus.done_o          = done;

endmodule
`default_nettype wire

// File: tb/tb_ascon_text_unpacker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ascon_text_unpacker
//  Brief    : Directed self-checking bench for ascon_text_unpacker.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ascon_text_unpacker;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   hs_count = 0;

    ascon_text_unpacker_if #(.SIZE_W(7)) bus ();

    ascon_text_unpacker #(.SIZE_W(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && bus.blk_valid_i && bus.blk_ready_o) hs_count++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_msg(input logic [6:0] size);
        bus.start_i     = 1'b1;
        bus.text_size_i = size;
        step();
        bus.start_i     = 1'b0;
    endtask

    task automatic send_block(input string tag, input logic [63:0] data);
        check_eq({tag, ".blk_ready"}, {63'h0, bus.blk_ready_o}, 64'h1);
        bus.blk_valid_i = 1'b1;
        bus.blk_data_i  = data;
        step();
        bus.blk_valid_i = 1'b0;
        bus.blk_data_i  = 64'h0;
    endtask

    task automatic recv(input string tag, input logic [31:0] d, input logic [3:0] m, input logic l);
        check_eq({tag, ".valid"}, {63'h0, bus.word_valid_o}, 64'h1);
        check_eq({tag, ".data"},  {32'h0, bus.word_data_o}, {32'h0, d});
        check_eq({tag, ".mask"},  {60'h0, bus.word_vld_byte_o}, {60'h0, m});
        check_eq({tag, ".last"},  {63'h0, bus.word_last_o}, {63'h0, l});
        step();
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, ".valid"}, {63'h0, bus.word_valid_o}, 64'h0);
        check_eq({tag, ".data"},  {32'h0, bus.word_data_o}, 64'h0);
        check_eq({tag, ".mask"},  {60'h0, bus.word_vld_byte_o}, 64'h0);
        check_eq({tag, ".last"},  {63'h0, bus.word_last_o}, 64'h0);
        check_eq({tag, ".ready"}, {63'h0, bus.blk_ready_o}, 64'h0);
        check_eq({tag, ".busy"},  {63'h0, bus.busy_o}, 64'h0);
        check_eq({tag, ".done"},  {63'h0, bus.done_o}, 64'h0);
    endtask

    initial begin
        int hs_before;
        rst_n           = 1'b0;
        bus.start_i     = 1'b0;
        bus.text_size_i = 7'd0;
        bus.blk_valid_i = 1'b0;
        bus.blk_data_i  = 64'h0;
        bus.word_ready_i = 1'b1;
        #2;
        check_idle_outputs("reset");
        step();
        step();
        rst_n = 1'b1;
        step();

        // Four full words, no stall
        start_msg(7'd16);
        send_block("t1.b0", 64'h0011223344556677);
        recv("t1.w0", 32'h00112233, 4'hF, 1'b0);
        recv("t1.w1", 32'h44556677, 4'hF, 1'b0);
        send_block("t1.b1", 64'h8899AABBCCDDEEFF);
        recv("t1.w2", 32'h8899AABB, 4'hF, 1'b0);
        recv("t1.w3", 32'hCCDDEEFF, 4'hF, 1'b1);
        check_eq("t1.done", {63'h0, bus.done_o}, 64'h1);
        step();
        check_eq("t1.done_end", {63'h0, bus.done_o}, 64'h0);
        check_eq("t1.busy_end", {63'h0, bus.busy_o}, 64'h0);

        // Odd tail, one valid byte in the last word
        start_msg(7'd13);
        send_block("t2.b0", 64'h0011223344556677);
        recv("t2.w0", 32'h00112233, 4'hF, 1'b0);
        recv("t2.w1", 32'h44556677, 4'hF, 1'b0);
        send_block("t2.b1", 64'h8899AABBCC800000);
        recv("t2.w2", 32'h8899AABB, 4'hF, 1'b0);
        recv("t2.w3", 32'hCC000000, 4'h8, 1'b1);
        check_eq("t2.done", {63'h0, bus.done_o}, 64'h1);
        step();

        // Single-word message; stray blk_valid afterwards must not be consumed
        hs_before = hs_count;
        start_msg(7'd4);
        send_block("t3.b0", 64'h1234567880000000);
        recv("t3.w0", 32'h12345678, 4'hF, 1'b1);
        bus.blk_valid_i = 1'b1;
        bus.blk_data_i  = 64'hFFFFFFFFFFFFFFFF;
        check_eq("t3.done", {63'h0, bus.done_o}, 64'h1);
        check_eq("t3.no_lo", {63'h0, bus.word_valid_o}, 64'h0);
        step();
        step();
        check_eq("t3.idle_busy", {63'h0, bus.busy_o}, 64'h0);
        bus.blk_valid_i = 1'b0;
        bus.blk_data_i  = 64'h0;
        check_eq("t3.handshakes", 64'(hs_count - hs_before), 64'h1);

        // Empty message
        start_msg(7'd0);
        check_eq("t4.c1.busy",  {63'h0, bus.busy_o}, 64'h1);
        check_eq("t4.c1.done",  {63'h0, bus.done_o}, 64'h0);
        check_eq("t4.c1.ready", {63'h0, bus.blk_ready_o}, 64'h0);
        check_eq("t4.c1.valid", {63'h0, bus.word_valid_o}, 64'h0);
        step();
        check_eq("t4.c2.busy",  {63'h0, bus.busy_o}, 64'h1);
        check_eq("t4.c2.done",  {63'h0, bus.done_o}, 64'h1);
        check_eq("t4.c2.ready", {63'h0, bus.blk_ready_o}, 64'h0);
        check_eq("t4.c2.valid", {63'h0, bus.word_valid_o}, 64'h0);
        step();
        check_eq("t4.c3.busy",  {63'h0, bus.busy_o}, 64'h0);
        check_eq("t4.c3.done",  {63'h0, bus.done_o}, 64'h0);

        // Backpressure on word 1 plus an ignored start during the stall
        start_msg(7'd6);
        bus.word_ready_i = 1'b0;
        send_block("t5.b0", 64'h11223344AABB8000);
        for (int i = 0; i < 3; i++) begin
            check_eq("t5.stall.valid", {63'h0, bus.word_valid_o}, 64'h1);
            check_eq("t5.stall.data",  {32'h0, bus.word_data_o}, 64'h11223344);
            check_eq("t5.stall.mask",  {60'h0, bus.word_vld_byte_o}, 64'hF);
            check_eq("t5.stall.last",  {63'h0, bus.word_last_o}, 64'h0);
            if (i == 1) begin
                start_msg(7'd20);
            end else begin
                step();
            end
        end
        bus.word_ready_i = 1'b1;
        recv("t5.w0", 32'h11223344, 4'hF, 1'b0);
        recv("t5.w1", 32'hAABB0000, 4'hC, 1'b1);
        check_eq("t5.done", {63'h0, bus.done_o}, 64'h1);
        step();

        // Asynchronous reset while in SEND_LO
        start_msg(7'd16);
        send_block("t6.b0", 64'h0123456789ABCDEF);
        recv("t6.w0", 32'h01234567, 4'hF, 1'b0);
        check_eq("t6.pre_rst.valid", {63'h0, bus.word_valid_o}, 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("t6.rst");
        step();
        rst_n = 1'b1;
        step();
        start_msg(7'd8);
        send_block("t6.b1", 64'hDEADBEEFCAFEF00D);
        recv("t6.w1", 32'hDEADBEEF, 4'hF, 1'b0);
        recv("t6.w2", 32'hCAFEF00D, 4'hF, 1'b1);
        check_eq("t6.done", {63'h0, bus.done_o}, 64'h1);
        step();
        check_eq("t6.idle", {63'h0, bus.busy_o}, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
